uart_tx_fifo: RTL

Transmit-side elastic buffer that sits directly upstream of the UART TX frame controller. It accepts parallel bytes from the host at any rate, stores up to `DEPTH` entries, and presents the head byte to the transmitter as `P_DATA` with `Data_Valid`. It pops one entry each time the transmitter signals that it has latched the byte, which lets the transmitter send back-to-back frames without host involvement.

---
 rtl/uart_tx_fifo.sv | 94 +++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit-side elastic buffer feeding the UART TX frame controller.
// The head entry is presented combinationally; tx_ld pops it when the TX latches it.
module uart_tx_fifo #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 8,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  flush,
  input  logic                  tx_ld,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  full,
  output logic                  empty,
  output logic [AW:0]           count,
  output logic                  overflow
);

  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]         wp_q, wp_d;
  logic [AW-1:0]         rp_q, rp_d;
  logic [AW:0]           count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  push_s, pop_s;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CNT_FULL);
  assign Data_Valid = ~empty;
  assign P_DATA     = mem_q[rp_q];
  assign count      = count_q;
  assign overflow   = overflow_q;

  always_comb begin
    pop_s      = tx_ld & ~empty;
    // A pop in the same cycle frees a slot, so a push at full is still accepted.
    push_s     = wr_en & (~full | pop_s);
    mem_d      = mem_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      wp_d       = '0;
      rp_d       = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_s) begin
        mem_d[wp_q] = wr_data;
        wp_d        = wp_q + PTR_ONE;
      end
      if (pop_s) begin
        rp_d = rp_q + PTR_ONE;
      end
      if (push_s && !pop_s) begin
        count_d = count_q + CNT_ONE;
      end else if (pop_s && !push_s) begin
        count_d = count_q - CNT_ONE;
      end else begin
        count_d = count_q;
      end
      if (wr_en && !push_s) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
